// File: rtl/multi_hit_filter.sv
// multi_hit_filter: per-channel hit synchroniser, glitch filter and
// dead-time gate with saturating accepted/dropped hit counters.
module multi_hit_filter #(
  parameter int NCH         = 4,
  parameter int NSYNC       = 2,
  parameter int MIN_WIDTH   = 2,
  parameter int DEAD_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     hit,
  input  logic [NCH-1:0]     hit_pol,
  input  logic [NCH-1:0]     ch_enable,
  input  logic               count_clr,
  output logic [NCH-1:0]     filtered_hit,
  output logic               valid,
  output logic [NCH*CNT_W-1:0] hit_count,
  output logic [NCH*CNT_W-1:0] drop_count
);

  localparam int WW = (MIN_WIDTH > 1) ? $clog2(MIN_WIDTH + 1) : 1;
  localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] QUAL = 2'd1;
  localparam logic [1:0] DEAD = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  logic valid_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [NSYNC-1:0] sync_q;
    logic             s;
    logic             s_prev_q;
    logic [1:0]       st_q, st_d;
    logic [WW-1:0]    wid_q, wid_d;
    logic [DW-1:0]    dead_q, dead_d;
    logic             fire_d, fire_q;
    logic             drop;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;

    assign s = sync_q[NSYNC-1];

    always_comb begin
      st_d   = st_q;
      wid_d  = wid_q;
      dead_d = dead_q;
      fire_d = 1'b0;
      drop   = 1'b0;
      unique case (st_q)
        IDLE: begin
          if (s) begin
            if (MIN_WIDTH == 1) begin
              fire_d = 1'b1;
              if (DEAD_CYCLES == 0) begin
                st_d = WAIT;
              end else begin
                st_d   = DEAD;
                dead_d = DW'(DEAD_CYCLES);
              end
            end else begin
              st_d  = QUAL;
              wid_d = WW'(1);
            end
          end
        end
        QUAL: begin
          if (!s) begin
            st_d = IDLE;
          end else if (wid_q == WW'(MIN_WIDTH - 1)) begin
            fire_d = 1'b1;
            if (DEAD_CYCLES == 0) begin
              st_d = WAIT;
            end else begin
              st_d   = DEAD;
              dead_d = DW'(DEAD_CYCLES);
            end
          end else begin
            wid_d = wid_q + WW'(1);
          end
        end
        DEAD: begin
          drop = s & ~s_prev_q;
          if (dead_q == '0) begin
            st_d = s ? WAIT : IDLE;
          end else begin
            dead_d = dead_q - DW'(1);
          end
        end
        WAIT: begin
          if (!s) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
      // disabling overrides everything, even a pulse decided this cycle
      if (!ch_enable[k]) begin
        st_d   = IDLE;
        fire_d = 1'b0;
        drop   = 1'b0;
      end
    end

    always_comb begin
      hcnt_d = count_clr ? '0 : hcnt_q;
      dcnt_d = count_clr ? '0 : dcnt_q;
      if (fire_d && hcnt_d != '1) hcnt_d = hcnt_d + CNT_W'(1);
      if (drop && dcnt_d != '1)   dcnt_d = dcnt_d + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q   <= '0;
        s_prev_q <= 1'b0;
        st_q     <= IDLE;
        wid_q    <= '0;
        dead_q   <= '0;
        fire_q   <= 1'b0;
        hcnt_q   <= '0;
        dcnt_q   <= '0;
      end else begin
        sync_q   <= {sync_q[NSYNC-2:0], hit[k] ^ hit_pol[k]};
        s_prev_q <= s;
        st_q     <= st_d;
        wid_q    <= wid_d;
        dead_q   <= dead_d;
        fire_q   <= fire_d;
        hcnt_q   <= hcnt_d;
        dcnt_q   <= dcnt_d;
      end
    end

    assign filtered_hit[k]               = fire_q;
    assign hit_count[k*CNT_W +: CNT_W]   = hcnt_q;
    assign drop_count[k*CNT_W +: CNT_W]  = dcnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= |filtered_hit;
  end

  assign valid = valid_q;

endmodule

// File: tb/tb_multi_hit_filter.sv
// tb_multi_hit_filter: directed table plus hand sequences for the
// hit filter, with a CNT_W=2 copy for counter saturation.
module tb_multi_hit_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  hit, pol, en;
  logic        clr;
  logic [3:0]  fh, fh2;
  logic        v, v2;
  logic [63:0] hc, dc;
  logic [7:0]  hc2, dc2;

  int ntest = 0;
  int nfail = 0;
  int pc [4];
  int vcnt;
  int both;

  always #5 clk = ~clk;

  multi_hit_filter u_dut (
    .clk(clk), .rst(rst), .hit(hit), .hit_pol(pol),
    .ch_enable(en), .count_clr(clr), .filtered_hit(fh),
    .valid(v), .hit_count(hc), .drop_count(dc)
  );

  multi_hit_filter #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .hit(hit), .hit_pol(pol),
    .ch_enable(en), .count_clr(clr), .filtered_hit(fh2),
    .valid(v2), .hit_count(hc2), .drop_count(dc2)
  );

  typedef struct {
    logic [3:0] hit;
    logic [3:0] exp_f;
    logic       exp_v;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [15:0] hcnt(input int k);
    return hc[k*16 +: 16];
  endfunction

  function automatic logic [15:0] dcnt(input int k);
    return dc[k*16 +: 16];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (fh[k]) pc[k]++;
    if (v) vcnt++;
    if (fh[0] && fh[3]) both++;
  endtask

  task automatic clr_pc();
    for (int k = 0; k < 4; k++) pc[k] = 0;
    vcnt = 0;
    both = 0;
  endtask

  task automatic run(input logic [3:0] h, input int n);
    hit = h;
    repeat (n) cyc();
  endtask

  logic [15:0] h0, d0;

  initial begin
    for (int r = 0; r < 18; r++) begin
      tbl[r].hit   = (r < 6) ? 4'b0001 : ((r == 10) ? 4'b0010 : 4'b0000);
      tbl[r].exp_f = (r == 3) ? 4'b0001 : 4'b0000;
      tbl[r].exp_v = (r == 4);
    end

    clr_pc();
    rst = 1'b1; hit = '0; pol = '0; en = 4'hF; clr = 1'b0;
    repeat (2) cyc();
    chk("rst_filt", 32'(fh), 32'h0);
    chk("rst_valid", 32'(v), 32'h0);
    chk("rst_hc", 32'(hc[31:0] | hc[63:32]), 32'h0);
    chk("rst_dc", 32'(dc[31:0] | dc[63:32]), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // single hit on ch0 then a one-sample glitch on ch1
    for (int r = 0; r < 18; r++) begin
      hit = tbl[r].hit;
      cyc();
      chk($sformatf("tbl_f[%0d]", r), 32'(fh), 32'(tbl[r].exp_f));
      chk($sformatf("tbl_v[%0d]", r), 32'(v), 32'(tbl[r].exp_v));
    end
    chk("t1_hc0", 32'(hcnt(0)), 32'd1);
    chk("t1_dc0", 32'(dcnt(0)), 32'd0);
    chk("t2_hc1", 32'(hcnt(1)), 32'd0);

    // dead time on ch2
    clr_pc();
    run(4'b0100, 2); run(4'b0000, 2); run(4'b0100, 2); run(4'b0000, 15);
    chk("t3_pulses", 32'(pc[2]), 32'd1);
    chk("t3_hc2", 32'(hcnt(2)), 32'd1);
    chk("t3_dc2", 32'(dcnt(2)), 32'd1);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("t3_clr", 32'(hcnt(2)), 32'd0);
    clr_pc();
    run(4'b0100, 2); run(4'b0000, 8); run(4'b0100, 2); run(4'b0000, 15);
    chk("t3b_pulses", 32'(pc[2]), 32'd2);
    chk("t3b_hc2", 32'(hcnt(2)), 32'd2);
    chk("t3b_dc2", 32'(dcnt(2)), 32'd0);

    // held level on ch3, active-high then active-low
    clr_pc();
    run(4'b1000, 50);
    chk("t4_held", 32'(pc[3]), 32'd1);
    run(4'b0000, 5); run(4'b1000, 4); run(4'b0000, 12);
    chk("t4_retrig", 32'(pc[3]), 32'd2);
    en = 4'b0111; pol = 4'b1000; hit = 4'b1000;
    repeat (5) cyc();
    en = 4'hF;
    clr_pc();
    run(4'b0000, 50);
    chk("t4n_held", 32'(pc[3]), 32'd1);
    run(4'b1000, 5); run(4'b0000, 4); run(4'b1000, 12);
    chk("t4n_retrig", 32'(pc[3]), 32'd2);
    en = 4'b0111; pol = 4'b0000; hit = 4'b0000;
    repeat (5) cyc();
    en = 4'hF;

    // simultaneous ch0/ch3
    clr_pc();
    run(4'b1001, 3); run(4'b0000, 12);
    chk("t5_p0", 32'(pc[0]), 32'd1);
    chk("t5_p3", 32'(pc[3]), 32'd1);
    chk("t5_same", 32'(both), 32'd1);
    chk("t5_valid", 32'(vcnt), 32'd1);

    // disable ch0 while in dead time
    h0 = hcnt(0); d0 = dcnt(0);
    clr_pc();
    run(4'b0001, 2);
    hit = 4'b0000;
    for (int i = 0; i < 10 && !fh[0]; i++) cyc();
    chk("t5_acc", 32'(fh[0]), 32'd1);
    cyc();
    en = 4'b1110;
    run(4'b0001, 4);
    chk("t5_dis_p", 32'(pc[0]), 32'd1);
    chk("t5_dis_hc", 32'(hcnt(0)), 32'(h0 + 16'd1));
    chk("t5_dis_dc", 32'(dcnt(0)), 32'(d0));
    en = 4'hF;
    cyc();
    chk("t5_reen1", 32'(fh[0]), 32'd0);
    cyc();
    chk("t5_reen2", 32'(fh[0]), 32'd1);
    run(4'b0000, 12);

    // saturation, clear-vs-increment, reset mid-QUAL
    clr = 1'b1; cyc(); clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run(4'b0010, 2); run(4'b0000, 12);
    end
    chk("t6_hc_full", 32'(hcnt(1)), 32'd5);
    chk("t6_hc_sat", 32'(hc2[3:2]), 32'd3);
    run(4'b0010, 3);
    chk("t6_pre", 32'(fh[1]), 32'd0);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("t6_clr_f", 32'(fh[1]), 32'd1);
    chk("t6_clr_hc", 32'(hcnt(1)), 32'd1);
    chk("t6_clr_sat", 32'(hc2[3:2]), 32'd1);
    run(4'b0000, 12);
    run(4'b0010, 3);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_f", 32'(fh), 32'd0);
    chk("t6_rst_v", 32'(v), 32'd0);
    chk("t6_rst_hc", 32'(hc[31:0] | hc[63:32]), 32'd0);
    chk("t6_rst_sat", 32'(hc2), 32'd0);
    #1 rst = 1'b0;
    repeat (3) cyc();
    chk("t6_post3", 32'(fh[1]), 32'd0);
    cyc();
    chk("t6_post4", 32'(fh[1]), 32'd1);
    chk("t6_post_hc", 32'(hcnt(1)), 32'd1);
    run(4'b0000, 10);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/multi_hit_filter.md
Name: multi_hit_filter

Overview:
- Multi-channel front-end conditioner for the TDC hit inputs.
- Per channel: synchronises the asynchronous hit, applies polarity selection, rejects glitches shorter than a minimum width, and emits one single-cycle filtered_hit pulse per accepted hit.
- Enforces a programmable dead time after each accepted hit and counts accepted and dropped hits.
- Sits between the detector pads and the delay-line/encoder channels; valid feeds the readout logic.

Parameters:
- NCH, 4, number of independent hit channels (>=1)
- NSYNC, 2, synchroniser depth per channel (>=2)
- MIN_WIDTH, 2, consecutive high samples required to accept a hit (>=1)
- DEAD_CYCLES, 4, holdoff cycles after an accepted hit (>=0)
- CNT_W, 16, width of each per-channel counter (>=2)

Ports:
- clk  input  1  single system clock
- rst  input  1  asynchronous reset, active high
- hit  input  NCH  raw asynchronous hit lines
- hit_pol  input  NCH  per channel: 0 = active-high hit, 1 = active-low hit (quasi-static)
- ch_enable  input  NCH  per-channel enable
- count_clr  input  1  synchronous clear of all counters
- filtered_hit  output  NCH  one-cycle pulse per accepted hit
- valid  output  1  filtered_hit OR-reduced, delayed one clock
- hit_count  output  NCH*CNT_W  accepted hits per channel; channel k occupies bits [k*CNT_W +: CNT_W]
- drop_count  output  NCH*CNT_W  hits seen during dead time per channel; same packing

Behaviour:
- Reset: one clock, clk; rst asynchronous active-high.
  - All flops clear immediately on rst: sync chains 0, FSMs IDLE, filtered_hit=0, valid=0, all counters 0.
  - rst release is synchronous to clk.
- Input conditioning:
  - s[k] = output of an NSYNC-stage synchroniser on (hit[k] XOR hit_pol[k]).
  - The synchroniser runs regardless of ch_enable.
- Per-channel FSM:
  - IDLE: if s=1, go to QUAL with width count = 1.
    - If MIN_WIDTH==1, skip QUAL: pulse filtered_hit next cycle and enter DEAD.
  - QUAL: if s=0, go to IDLE (glitch rejected, no count). Otherwise increment the width count; on reaching MIN_WIDTH, pulse filtered_hit for exactly one cycle and enter DEAD with the dead counter loaded to DEAD_CYCLES.
  - DEAD: decrement each cycle.
    - A rising edge of s (s=1, previous s=0) during DEAD increments drop_count.
    - When the counter reaches 0: go to IDLE if s=0, else go to WAIT_LOW.
    - DEAD_CYCLES==0: DEAD lasts zero cycles; take the exit decision immediately.
  - WAIT_LOW: stay while s=1; go to IDLE when s=0. A held-high hit never retriggers.
- Latency: the rising clk edge at which filtered_hit[k] goes high is NSYNC+MIN_WIDTH edges after the first edge that samples the active hit level. Defaults give 4.
- valid: registered |filtered_hit; high exactly one cycle after any filtered_hit pulse.
  - Simultaneous pulses on several channels give a single valid cycle.
- Minimum spacing between accepted hits on one channel: MIN_WIDTH+DEAD_CYCLES+1 cycles, plus any WAIT_LOW time.
- ch_enable[k]=0:
  - FSM forced to IDLE immediately, including mid-QUAL or mid-DEAD.
  - No filtered_hit pulses; counters hold their value.
  - Re-enabling with s=1 starts QUAL on the next cycle.
- Counters:
  - hit_count increments on each filtered_hit pulse; drop_count as above.
  - Both saturate at all-ones, never wrap.
  - count_clr clears all counters. If count_clr coincides with an increment, the result is 1: the clear applies, then the same-cycle event is counted.
- hit_pol changes are asynchronous to the FSM and may generate one spurious edge; software changes hit_pol only while the channel is disabled.
- Reset asserted mid-operation: every state is lost, no pulse is emitted.
  - After release, a hit still held active counts as a new hit after the normal latency.

Test Plan:
1. Single hit, defaults, ch0 active-high, high 6 cycles → filtered_hit[0] high for one cycle at edge 4; valid high at edge 5; hit_count[0]=1; drop_count[0]=0.
2. Glitch: ch1 high for exactly 1 sample with MIN_WIDTH=2 → no filtered_hit, valid stays 0, hit_count[1]=0.
3. Dead time: two 2-cycle hits on ch2, 4 cycles apart (second edge inside DEAD) → one pulse, hit_count[2]=1, drop_count[2]=1. Repeated 10 cycles apart → two pulses, hit_count[2]=2.
4. Held-high level on ch3 for 50 cycles → exactly one pulse; the next pulse only after a low then high transition. hit_pol[3]=1 with an active-low hit → identical result.
5. Channels 0 and 3 hit on the same edge → both filtered_hit bits pulse in the same cycle; valid high for one cycle only. Disabling ch0 mid-DEAD → FSM returns to IDLE and counters hold.
6. CNT_W=2: five accepted hits → hit_count saturates at 3. count_clr coinciding with a pulse → count=1. rst asserted mid-QUAL → outputs 0 immediately; hit still high after release → pulse at edge 4 after release.
